// File: rtl/rr_x_in_arbiter_if.sv
// Handshake bundle between input-port routing stage and the output arbiter.
// Requester side drives req/last/ready; arbiter drives grant/id/busy/err.
interface rr_x_in_arbiter_if #(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3
);
    logic [IO_SIZE-1:0] req_i;
    logic [IO_SIZE-1:0] last_i;
    logic               ready_i;
    logic [IO_SIZE-1:0] grant_o;
    logic [IO_w-1:0]    grant_id_o;
    logic               busy_o;
    logic               err_o;

    modport master (
        output req_i, last_i, ready_i,
        input  grant_o, grant_id_o, busy_o, err_o
    );

    modport slave (
        input  req_i, last_i, ready_i,
        output grant_o, grant_id_o, busy_o, err_o
    );
endinterface

// File: rtl/rr_x_in_arbiter.sv
// Packet-granular round-robin arbiter for one switch output port.
// Ports: clk, rst_n (async active-low), arb (slave: req/last/ready in, grant/id/busy/err out).
module rr_x_in_arbiter #(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_x_in_arbiter_if.slave    arb
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OWNED = 1'b1;

    logic [0:0]         r_state;
    logic [IO_w-1:0]    r_ptr;
    logic [IO_SIZE-1:0] r_grant;
    logic [IO_w-1:0]    r_grant_id;
    logic               r_busy;
    logic               r_err;

    logic               w_owner_req;
    logic               w_owner_last;
    logic               w_xfer;
    logic [IO_w-1:0]    w_next_ptr;
    logic [IO_SIZE-1:0] w_pick_idle;
    logic [IO_SIZE-1:0] w_pick_rel;

    // Masked pass covers indices >= ptr, unmasked pass wraps to the rest.
    function automatic logic [IO_SIZE-1:0] f_rr_pick(
        input logic [IO_SIZE-1:0] req,
        input logic [IO_w-1:0]    ptr
    );
        logic [IO_SIZE-1:0] mask;
        logic [IO_SIZE-1:0] masked;
        mask = '0;
        for (int i = 0; i < IO_SIZE; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = req & mask;
        if (|masked) begin
            return masked & (~masked + IO_SIZE'(1));
        end
        return req & (~req + IO_SIZE'(1));
    endfunction

    function automatic logic [IO_w-1:0] f_enc(input logic [IO_SIZE-1:0] oh);
        logic [IO_w-1:0] id;
        id = '0;
        for (int i = 0; i < IO_SIZE; i++) begin
            if (oh[i]) id = IO_w'(i);
        end
        return id;
    endfunction

    always_comb begin
        w_owner_req  = |(arb.req_i & r_grant);
        w_owner_last = |(arb.last_i & r_grant);
        w_xfer       = arb.ready_i & w_owner_req;
        // Priority moves to the input just after the current owner.
        w_next_ptr   = (r_grant_id == IO_w'(IO_SIZE - 1)) ?
                       '0 : r_grant_id + IO_w'(1);
        w_pick_idle  = f_rr_pick(arb.req_i, r_ptr);
        w_pick_rel   = f_rr_pick(arb.req_i, w_next_ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|arb.req_i) begin
                        r_grant    <= w_pick_idle;
                        r_grant_id <= f_enc(w_pick_idle);
                        r_busy     <= 1'b1;
                        r_state    <= S_OWNED;
                    end
                end
                S_OWNED: begin
                    if (w_xfer && w_owner_last) begin
                        // Tail accepted: hand over with no bubble if anyone waits.
                        r_ptr <= w_next_ptr;
                        if (|arb.req_i) begin
                            r_grant    <= w_pick_rel;
                            r_grant_id <= f_enc(w_pick_rel);
                        end else begin
                            r_grant    <= '0;
                            r_grant_id <= '0;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end else if (!w_owner_req) begin
                        // Owner vanished mid-packet.
                        r_err      <= 1'b1;
                        r_ptr      <= w_next_ptr;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_grant    <= '0;
                    r_grant_id <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign arb.grant_o    = r_grant;
    assign arb.grant_id_o = r_grant_id;
    assign arb.busy_o     = r_busy;
    assign arb.err_o      = r_err;

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(r_grant)
    );

    a_busy_match: assert property (
        @(posedge clk) disable iff (!rst_n) r_busy == (|r_grant)
    );
endmodule

// File: tb/tb_rr_x_in_arbiter.sv
// Bench for rr_x_in_arbiter: directed scenarios plus random traffic
// checked against a queue-free index-based round-robin model.
module tb_rr_x_in_arbiter;
    localparam int N = 5;
    localparam int W = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    int   m_owner;
    int   m_ptr;
    logic m_err;

    rr_x_in_arbiter_if #(.IO_SIZE(N), .IO_w(W)) bus ();

    rr_x_in_arbiter #(.IO_SIZE(N), .IO_w(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] e_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [W-1:0] e_id();
        return (m_owner < 0) ? '0 : W'(m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_err   = 1'b0;
    endtask

    task automatic tick();
        int o;
        logic [N-1:0] r;
        r = bus.req_i;
        o = m_owner;
        m_err = 1'b0;
        if (o < 0) begin
            if (r != '0) m_owner = pick(r, m_ptr);
        end else if (bus.ready_i && r[o] && bus.last_i[o]) begin
            m_ptr   = (o + 1) % N;
            m_owner = pick(r, m_ptr);
        end else if (!r[o]) begin
            m_err   = 1'b1;
            m_ptr   = (o + 1) % N;
            m_owner = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req_i   = '0;
        bus.last_i  = '0;
        bus.ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.grant_o, bus.grant_id_o, bus.busy_o, bus.err_o} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b want=0",
                     {bus.grant_o, bus.grant_id_o, bus.busy_o, bus.err_o});
        end
        bus.req_i   = 5'b00100;
        bus.ready_i = 1'b1;
        tick();
        total++;
        if (bus.grant_o !== 5'b00100) begin
            bad++;
            $display("FAIL reset_pre_grant got=%b want=00100", bus.grant_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.grant_o !== 5'b00000 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got=%b/%b want=00000/0",
                     bus.grant_o, bus.busy_o);
        end
        model_reset();
        bus.req_i = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.req_i = 5'b11111;
        tick();
        total++;
        if (bus.grant_o !== 5'b00001) begin
            bad++;
            $display("FAIL reset_first_grant got=%b want=00001", bus.grant_o);
        end
    endtask

    task automatic test_rotation();
        int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
        do_reset();
        bus.req_i   = 5'b11111;
        bus.last_i  = 5'b11111;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus.grant_id_o !== W'(exp_seq[i]) || bus.busy_o !== 1'b1) begin
                bad++;
                $display("FAIL rotation[%0d] got=%0d busy=%b want=%0d busy=1",
                         i, bus.grant_id_o, bus.busy_o, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req_i   = 5'b01000;
        bus.last_i  = 5'b01000;
        bus.ready_i = 1'b1;
        tick();
        total++;
        if (bus.grant_o !== 5'b01000) begin
            bad++;
            $display("FAIL wrap_setup got=%b want=01000", bus.grant_o);
        end
        bus.req_i = 5'b01110;
        tick();
        total++;
        if (bus.grant_o !== 5'b00010) begin
            bad++;
            $display("FAIL wrap_ptr4 got=%b want=00010", bus.grant_o);
        end
        bus.req_i  = 5'b00110;
        bus.last_i = 5'b00010;
        tick();
        total++;
        if (bus.grant_o !== 5'b00100) begin
            bad++;
            $display("FAIL wrap_ptr2 got=%b want=00100", bus.grant_o);
        end
    endtask

    task automatic test_hold();
        int   flits;
        logic released;
        logic rel_now;
        do_reset();
        bus.req_i   = 5'b00010;
        bus.ready_i = 1'b1;
        tick();
        total++;
        if (bus.grant_o !== 5'b00010) begin
            bad++;
            $display("FAIL hold_setup got=%b want=00010", bus.grant_o);
        end
        bus.req_i = 5'b11111;
        flits     = 0;
        released  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!released) begin
                bus.ready_i = (i % 2 == 0);
                rel_now     = bus.ready_i && (flits == 3);
                bus.last_i  = rel_now ? 5'b00010 : 5'b00000;
                tick();
                total++;
                if (bus.grant_o !== (rel_now ? 5'b00100 : 5'b00010)) begin
                    bad++;
                    $display("FAIL hold[%0d] got=%b want=%b", i, bus.grant_o,
                             rel_now ? 5'b00100 : 5'b00010);
                end
                if (bus.ready_i) flits++;
                if (rel_now) released = 1'b1;
            end
        end
        bus.last_i = '0;
        total++;
        if (released !== 1'b1 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got=%b/%b want=1/1", released, bus.busy_o);
        end
    endtask

    task automatic test_abort();
        do_reset();
        bus.req_i   = 5'b01000;
        bus.ready_i = 1'b1;
        tick();
        bus.req_i = 5'b00000;
        tick();
        total++;
        if (bus.err_o !== 1'b1 || bus.grant_o !== 5'b00000 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_pulse got=err%b g%b b%b want=err1 g00000 b0",
                     bus.err_o, bus.grant_o, bus.busy_o);
        end
        bus.req_i = 5'b11111;
        tick();
        total++;
        if (bus.err_o !== 1'b0 || bus.grant_o !== 5'b10000) begin
            bad++;
            $display("FAIL abort_after got=err%b g%b want=err0 g10000",
                     bus.err_o, bus.grant_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req_i   = 5'b00100;
        bus.last_i  = 5'b00100;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus.grant_o !== 5'b00100 || bus.busy_o !== 1'b1) begin
                bad++;
                $display("FAIL sole[%0d] got=%b/%b want=00100/1",
                         i, bus.grant_o, bus.busy_o);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] hold;
        logic [N-1:0] lst;
        do_reset();
        hold = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(7) == 0) hold[j] = ~hold[j];
                lst[j] = ($urandom_range(2) == 0);
            end
            bus.req_i   = hold;
            bus.last_i  = lst;
            bus.ready_i = ($urandom_range(3) != 0);
            tick();
            total++;
            if ({bus.grant_o, bus.grant_id_o, bus.busy_o, bus.err_o} !==
                {e_grant(), e_id(), m_owner >= 0, m_err}) begin
                bad++;
                $display("FAIL random[%0d] got=g%b id%0d b%b e%b want=g%b id%0d b%b e%b",
                         c, bus.grant_o, bus.grant_id_o, bus.busy_o, bus.err_o,
                         e_grant(), e_id(), m_owner >= 0, m_err);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        test_reset();
        test_rotation();
        test_wrap();
        test_hold();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
